// File: rtl/fp_to_lin.sv
// fp_to_lin: serial 8-bit float code (S,E,F) to 12-bit two's-complement linear value.
// One conversion in flight; result held until the output handshake completes.
module fp_to_lin (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  fp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] lin_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] mag_q, mag_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d;
    logic [11:0] lin_q, lin_d;
    logic        out_valid_q, out_valid_d;

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            lin_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            lin_q       <= lin_d;
            out_valid_q <= out_valid_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (cnt_q == 3'd0) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // datapath updates tied to the current state
    always_comb begin
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        lin_d       = lin_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mag_d = {8'b0, fp_in[3:0]};
                    cnt_d = fp_in[6:4];
                    sgn_d = fp_in[7];
                end
            end
            SHIFT: begin
                if (cnt_q != 3'd0) begin
                    mag_d = {mag_q[10:0], 1'b0};
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    // negating zero yields zero, so -0 needs no special case
                    lin_d       = sgn_q ? (~mag_q + 12'd1) : mag_q;
                    out_valid_d = 1'b1;
                end
            end
            OUT: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // state-decoded outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = out_valid_q;
        lin_out   = lin_q;
    end

endmodule

// File: doc/fp_to_lin.md
FP_TO_LIN -- requirements
Module: fp_to_lin

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clk  input  1  rising-edge clock; the block has one clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  fp_in holds a code to convert.
REQ-005 in_ready  output  1  block can accept a code this cycle.
REQ-006 fp_in  input  8  float code: [7]=S sign, [6:4]=E exponent, [3:0]=F significand.
REQ-007 out_valid  output  1  lin_out holds a result.
REQ-008 out_ready  input  1  downstream accepts the result this cycle.
REQ-009 lin_out  output  12  two's-complement linear value.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 Result SHALL be (-1)^S * F * 2^E, encoded as 12-bit two's complement; |result| max = 15*128 = 1920, so no overflow or saturation path exists.
REQ-012 F SHALL be taken as given; non-normalized F (F[3]=0) is legal and decodes exactly.
REQ-013 Negative zero (S=1, F=0) SHALL produce 12'h000.
REQ-014 FSM states: IDLE, SHIFT, OUT. in_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-015 IDLE: when in_valid && in_ready, the block SHALL latch mag={8'b0,F}, cnt=E, sgn=S and go to SHIFT; otherwise it stays in IDLE.
REQ-016 SHIFT, cnt!=0: mag SHALL shift left 1 bit and cnt decrements by 1 in the same cycle.
REQ-017 SHIFT, cnt==0: lin_out SHALL be loaded with sgn ? (~mag+1) : mag, out_valid set to 1, and the FSM goes to OUT.
REQ-018 Latency: out_valid SHALL rise exactly E+1 cycles after the accept edge; E=0 gives 1 cycle, E=7 gives 8.
REQ-019 OUT: lin_out and out_valid SHALL hold stable while out_ready=0.
REQ-020 OUT with out_ready=1: out_valid SHALL clear on that edge and the FSM goes to IDLE; the next accept is possible on the following cycle (no overlap).
REQ-021 in_valid while busy SHALL be ignored; fp_in is not sampled outside IDLE.
REQ-022 lin_out SHALL keep its last value after the output handshake until the next SHIFT-to-OUT load.
REQ-023 Encoder round trip: decoding an encoder output yields the encoder's rounded value, e.g. 125 encodes to 8'h48, which decodes to 128.

Reset
REQ-024 With rst=1 at a clock edge: state=IDLE, out_valid=0, lin_out=12'h000, mag=0, cnt=0, sgn=0; in_ready=1 and busy=0 from the next cycle.
REQ-025 rst SHALL override every state, including mid-SHIFT and OUT; the in-flight conversion is discarded and no out_valid pulse follows.
REQ-026 rst SHALL take priority over a simultaneous in_valid/out_ready handshake.

Verification
REQ-027 fp_in=8'h00, out_ready=1 -> out_valid 1 cycle after accept, lin_out=12'h000.
REQ-028 fp_in=8'h2D (E=2, F=13) -> out_valid 3 cycles after accept, lin_out=12'd52.
REQ-029 fp_in=8'hFF -> out_valid 8 cycles after accept, lin_out=12'h880 (-1920); fp_in=8'h80 -> lin_out=12'h000.
REQ-030 fp_in=8'h48, out_ready=0 for 5 cycles -> lin_out=12'd128 held with out_valid=1 and in_ready=0; a new in_valid during the wait is ignored; raising out_ready returns the FSM to IDLE.
REQ-031 fp_in=8'hF0 accepted, rst pulsed at SHIFT cycle 3 -> the next cycle shows in_ready=1, out_valid=0, lin_out=0, and no result appears.
REQ-032 Back-to-back codes 8'h13 then 8'h93 with out_ready=1 -> lin_out=+6 then -6 (12'hFFA), each with its own single out_valid pulse.
